// File: rtl/mips_mem_responder_pkg.sv
// Shared types, macros and the strobe-merge helper for the MIPS memory responder.
// Build option: MIPS_MEM_CYCLE_COUNTER_EN enables the memory-mapped cycle counter.
`ifndef MIPS_MEM_DEFS_VH
`define MIPS_MEM_DEFS_VH
`define MEM_COUNTER_ADDR 32'hFFFF_0000
`define WB_IDX_W(D) ($clog2(D))
`define WB_ENTRY_W(IW) ((IW) + 36)
`endif

package mips_mem_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  function automatic word_t strb_merge(
    input word_t base,
    input word_t data,
    input strb_t strb
  );
    word_t r;
    r = base;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Core-to-memory bus: fetch port, data port and buffer status.
// master = core side, slave = memory responder side.
interface mips_mem_responder_if #(
  parameter int WB_DEPTH = 4
) ();
  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic [31:0]   PC;
  logic [31:0]   Instruction;
  logic [31:0]   Address;
  logic          MemWrite;
  logic [31:0]   Write_data;
  logic [3:0]    Write_strb;
  logic          MemRead;
  logic [31:0]   Read_data;
  logic          Busy;
  logic [CW-1:0] wb_count;

  modport master (
    output PC, Address, MemWrite, Write_data, Write_strb, MemRead,
    input  Instruction, Read_data, Busy, wb_count
  );

  modport slave (
    input  PC, Address, MemWrite, Write_data, Write_strb, MemRead,
    output Instruction, Read_data, Busy, wb_count
  );
endinterface

// File: rtl/mips_mem_responder_write_buffer.sv
// Posted store FIFO with byte-merge forwarding of pending entries.
// Entry layout: {word idx, data, strb}; pointers wrap naturally.
module mem_write_buffer
  import mips_mem_responder_pkg::*;
#(
  parameter  int IDX_W = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = `WB_IDX_W(DEPTH),
  localparam int EW    = `WB_ENTRY_W(IDX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [IDX_W-1:0] i_idx,
  input  word_t            i_data,
  input  strb_t            i_strb,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  word_t            i_rd_base,
  output logic [IDX_W-1:0] o_head_idx,
  output word_t            o_head_data,
  output strb_t            o_head_strb,
  output logic [PW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output word_t            o_fwd_data
);

  logic [EW-1:0] r_ent [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;
  logic [EW-1:0] w_head;

  assign w_head      = r_ent[r_rd];
  assign o_head_idx  = w_head[EW-1 -: IDX_W];
  assign o_head_data = w_head[35:4];
  assign o_head_strb = w_head[3:0];
  assign o_count     = r_cnt;
  assign o_full      = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty     = (r_cnt == '0);

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk)
    if (i_push && !rst)
      r_ent[r_wr] <= {i_idx, i_data, i_strb};

  // Pointers and occupancy; reset wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      if (i_push && !i_pop)      r_cnt <= r_cnt + 1'b1;
      else if (i_pop && !i_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Overlay matching entries oldest-first so the newest byte wins.
  always_comb begin
    logic [PW-1:0] v_pos;
    logic [EW-1:0] v_e;
    o_fwd_data = i_rd_base;
    for (int k = 0; k < DEPTH; k++) begin
      v_pos = r_rd + PW'(k);
      v_e   = r_ent[v_pos];
      if (((PW+1)'(k) < r_cnt) && (v_e[EW-1 -: IDX_W] == i_rd_idx))
        o_fwd_data = strb_merge(o_fwd_data, v_e[35:4], v_e[3:0]);
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder: word RAM, combinational fetch/load, posted store buffer.
// Build option: MIPS_MEM_CYCLE_COUNTER_EN maps a cycle counter at `MEM_COUNTER_ADDR.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WB_DEPTH       = 4
) (
  input logic                  clk,
  input logic                  rst,
  mips_mem_responder_if.slave  bus
);

  localparam int IW    = MEM_ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IW;
  localparam int CW    = $clog2(WB_DEPTH) + 1;

  word_t r_ram [WORDS];

  logic [IW-1:0] w_pc_idx;
  logic [IW-1:0] w_ad_idx;
  logic [IW-1:0] w_hd_idx;
  word_t         w_hd_data;
  strb_t         w_hd_strb;
  logic [CW-1:0] w_cnt;
  logic          w_full;
  logic          w_empty;
  word_t         w_fwd;
  logic          w_drain;
  logic          w_push;
  logic          w_cnt_hit;
  word_t         w_cyc;
  logic          w_unused;

  assign w_pc_idx = bus.PC[MEM_ADDR_WIDTH-1:2];
  assign w_ad_idx = bus.Address[MEM_ADDR_WIDTH-1:2];
  assign w_unused = ^{bus.PC[31:MEM_ADDR_WIDTH], bus.PC[1:0],
                      bus.Address[31:MEM_ADDR_WIDTH], bus.Address[1:0]};

`ifdef MIPS_MEM_CYCLE_COUNTER_EN
  word_t r_cyc;

  // Free-running cycle counter, zero in the first cycle after reset.
  always_ff @(posedge clk)
    if (rst) r_cyc <= '0;
    else     r_cyc <= r_cyc + 32'd1;

  assign w_cyc     = r_cyc;
  assign w_cnt_hit = (bus.Address == `MEM_COUNTER_ADDR);
`else
  assign w_cyc     = '0;
  assign w_cnt_hit = 1'b0;
`endif

  assign w_drain = !bus.MemRead && !w_empty;
  assign w_push  = bus.MemWrite && (bus.Write_strb != '0) &&
                   (!w_full || w_drain) && !w_cnt_hit;

  mem_write_buffer #(
    .IDX_W (IW),
    .DEPTH (WB_DEPTH)
  ) u_wb (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_drain),
    .i_idx       (w_ad_idx),
    .i_data      (bus.Write_data),
    .i_strb      (bus.Write_strb),
    .i_rd_idx    (w_ad_idx),
    .i_rd_base   (r_ram[w_ad_idx]),
    .o_head_idx  (w_hd_idx),
    .o_head_data (w_hd_data),
    .o_head_strb (w_hd_strb),
    .o_count     (w_cnt),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_fwd_data  (w_fwd)
  );

  // Drain the oldest buffered store into RAM on idle data-port cycles.
  always_ff @(posedge clk)
    if (!rst && w_drain)
      r_ram[w_hd_idx] <= strb_merge(r_ram[w_hd_idx], w_hd_data, w_hd_strb);

  assign bus.Instruction = r_ram[w_pc_idx];
  assign bus.Read_data   = !bus.MemRead ? '0 :
                           w_cnt_hit    ? w_cyc : w_fwd;
  assign bus.Busy        = w_full;
  assign bus.wb_count    = w_cnt;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: forwarding, buffer full/drain,
// reset discard and (optionally) the cycle counter.
module tb_mips_mem_responder;

  localparam logic [31:0] CNT_ADDR = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mips_mem_responder_if #(.WB_DEPTH(4)) bus ();

  mips_mem_responder #(
    .MEM_ADDR_WIDTH (10),
    .WB_DEPTH       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    bus.MemWrite   = 1'b1;
    bus.Address    = a;
    bus.Write_data = d;
    bus.Write_strb = s;
    tick();
    bus.MemWrite   = 1'b0;
    bus.Write_strb = 4'h0;
  endtask

  task automatic ld(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    logic old;
    old         = bus.MemRead;
    bus.MemRead = 1'b1;
    bus.Address = a;
    #1;
    chk(tag, bus.Read_data, exp);
    bus.MemRead = old;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
    bus.PC = a;
    #1;
    chk(tag, bus.Instruction, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.PC = '0; bus.Address = '0; bus.MemWrite = 1'b0;
    bus.Write_data = '0; bus.Write_strb = '0; bus.MemRead = 1'b0;
    tick(); tick();
    chk("rst_cnt", 32'(bus.wb_count), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    rst = 1'b0;

    // 1: store then idle drain, load back
    st(32'h10, 32'h1122_3344, 4'hF);
    chk("t1_pend", 32'(bus.wb_count), 1);
    #1;
    chk("t1_rd0", bus.Read_data, 0);
    tick();
    chk("t1_cnt", 32'(bus.wb_count), 0);
    ld("t1_ld", 32'h10, 32'h1122_3344);
    fetch("t1_if", 32'h10, 32'h1122_3344);
    fetch("t1_alias", 32'h412, 32'h1122_3344);

    // 2: forwarding of a partial store, not visible to fetch
    st(32'h20, 32'h1234_5678, 4'hF);
    tick();
    bus.MemRead    = 1'b1;
    bus.Address    = 32'h20;
    bus.MemWrite   = 1'b1;
    bus.Write_data = 32'hAAAA_BBBB;
    bus.Write_strb = 4'b0011;
    #1;
    chk("t2_nofwd", bus.Read_data, 32'h1234_5678);
    tick();
    bus.MemWrite = 1'b0;
    bus.Write_strb = 4'h0;
    #1;
    chk("t2_fwd", bus.Read_data, 32'h1234_BBBB);
    chk("t2_cnt", 32'(bus.wb_count), 1);
    fetch("t2_if", 32'h20, 32'h1234_5678);
    bus.MemRead = 1'b0;
    tick();
    chk("t2_cnt0", 32'(bus.wb_count), 0);
    ld("t2_ram", 32'h20, 32'h1234_BBBB);

    // 3: fill, drop when full, push+drain, drain out
    st(32'h50, 32'h5555_5555, 4'hF);
    tick();
    bus.MemRead = 1'b1;
    for (int i = 0; i < 4; i++)
      st(32'h40 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
    chk("t3_full", 32'(bus.wb_count), 4);
    chk("t3_busy", 32'(bus.Busy), 1);
    st(32'h50, 32'hDEAD_BEEF, 4'hF);
    chk("t3_drop", 32'(bus.wb_count), 4);
    bus.MemRead = 1'b0;
    tick();
    chk("t3_cnt3", 32'(bus.wb_count), 3);
    chk("t3_busy0", 32'(bus.Busy), 0);
    st(32'h54, 32'h5454_5454, 4'hF);
    chk("t3_pushdrain", 32'(bus.wb_count), 3);
    tick(); tick(); tick();
    chk("t3_empty", 32'(bus.wb_count), 0);
    ld("t3_w0", 32'h40, 32'hA0);
    ld("t3_w3", 32'h4C, 32'hA3);
    ld("t3_nodrop", 32'h50, 32'h5555_5555);
    ld("t3_w54", 32'h54, 32'h5454_5454);

    // 4: newest byte wins; zero strobe is a no-op
    bus.MemRead = 1'b1;
    st(32'h60, 32'h0102_0304, 4'hF);
    st(32'h60, 32'hFF00_0000, 4'b1000);
    st(32'h60, 32'h7777_7777, 4'h0);
    chk("t4_cnt", 32'(bus.wb_count), 2);
    ld("t4_fwd", 32'h60, 32'hFF02_0304);
    bus.MemRead = 1'b0;
    tick(); tick();
    chk("t4_cnt0", 32'(bus.wb_count), 0);
    ld("t4_ram", 32'h60, 32'hFF02_0304);

    // 5: reset discards pending stores, RAM untouched
    bus.MemRead = 1'b1;
    st(32'h10, 32'hBAD0_BAD0, 4'hF);
    st(32'h20, 32'hBAD1_BAD1, 4'hF);
    st(32'h60, 32'hBAD2_BAD2, 4'hF);
    chk("t5_cnt3", 32'(bus.wb_count), 3);
    bus.MemRead = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_cnt", 32'(bus.wb_count), 0);
    chk("t5_busy", 32'(bus.Busy), 0);
    ld("t5_w10", 32'h10, 32'h1122_3344);
    ld("t5_w20", 32'h20, 32'h1234_BBBB);
    ld("t5_w60", 32'h60, 32'hFF02_0304);

`ifdef MIPS_MEM_CYCLE_COUNTER_EN
    // 6: counter read and discarded store
    ld("t6_cyc0", CNT_ADDR, 32'd0);
    repeat (10) tick();
    ld("t6_cyc10", CNT_ADDR, 32'd10);
    st(CNT_ADDR, 32'h1234, 4'hF);
    chk("t6_nostore", 32'(bus.wb_count), 0);
`else
    // 6: counter address aliases into RAM word 0
    bus.MemRead = 1'b1;
    st(CNT_ADDR, 32'h0BAD_F00D, 4'hF);
    chk("t6_alias_cnt", 32'(bus.wb_count), 1);
    ld("t6_alias_fwd", 32'h0, 32'h0BAD_F00D);
    bus.MemRead = 1'b0;
    tick();
    fetch("t6_alias_if", 32'h0, 32'h0BAD_F00D);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
